// File: rtl/mem_responder_if.sv
// Request/ready/valid bundle between the CPU's fetch and data initiators
// and the memory responder.
interface mem_responder_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ready;
   logic        i_valid;
   logic [31:0] i_rdata;
   logic        i_err;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        d_err;

   modport slave (
      input  i_req, i_addr,
      output i_ready, i_valid, i_rdata, i_err,
      input  d_req, d_we, d_addr, d_wdata,
      output d_ready, d_valid, d_rdata, d_err
   );

   modport master (
      output i_req, i_addr,
      input  i_ready, i_valid, i_rdata, i_err,
      output d_req, d_we, d_addr, d_wdata,
      input  d_ready, d_valid, d_rdata, d_err
   );
endinterface

// File: rtl/mem_responder.sv
// Single-ported word memory serving fetch and data initiators with
// data-priority arbitration, a fetch starvation guard and a fixed-latency response pipe.
module mem_responder #(
   parameter int ADDRW   = 16,
   parameter int LATENCY = 2,
   parameter int STARVE  = 4
) (
   input  logic            clock,
   input  logic            reset_n,
   mem_responder_if.slave  bus
);

   localparam int          DEPTH    = 2 ** ADDRW;
   localparam logic [32:0] DEPTH_C  = 33'(DEPTH);
   localparam logic [3:0]  STARVE_C = 4'(STARVE);

   typedef struct packed {
      logic        valid;
      logic        port;   // 1 = data port, 0 = fetch port
      logic        err;
      logic [31:0] data;
   } rsp_t;

   logic [31:0]      mem_q [DEPTH];
   logic [3:0]       starve_cnt_q, starve_cnt_d;
   logic             force_s, d_ready_s, i_ready_s;
   logic             any_acc_s, addr_err_s, wr_en_s;
   logic [31:0]      addr_s;
   logic [ADDRW-1:0] idx_s;
   rsp_t             acc_s, last_in_s;

   logic             i_valid_q, i_valid_d, i_err_q, i_err_d;
   logic             d_valid_q, d_valid_d, d_err_q, d_err_d;
   logic [31:0]      i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

   // Grant: data wins unless fetch has been starved long enough.
   always_comb begin
      force_s   = (starve_cnt_q == STARVE_C);
      d_ready_s = bus.d_req & ~(force_s & bus.i_req);
      i_ready_s = bus.i_req & (~bus.d_req | force_s);
   end

   // Starvation counter next state.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!bus.i_req || i_ready_s) begin
         starve_cnt_d = 4'd0;
      end else if (starve_cnt_q != STARVE_C) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   // Build the response entry for whichever request is accepted this cycle.
   always_comb begin
      any_acc_s  = d_ready_s | i_ready_s;
      addr_s     = d_ready_s ? bus.d_addr : bus.i_addr;
      idx_s      = addr_s[ADDRW+1:2];
      addr_err_s = (addr_s[1:0] != 2'b00) || ({3'b000, addr_s[31:2]} >= DEPTH_C);
      wr_en_s    = d_ready_s & bus.d_we & ~addr_err_s;
      acc_s.valid = any_acc_s;
      acc_s.port  = d_ready_s;
      acc_s.err   = any_acc_s & addr_err_s;
      if (any_acc_s && !addr_err_s && !(d_ready_s && bus.d_we)) begin
         acc_s.data = mem_q[idx_s];
      end else begin
         acc_s.data = 32'h0000_0000;
      end
   end

   // Memory array: not reset, so stored data survives reset.
   always_ff @(posedge clock) begin
      if (wr_en_s) begin
         mem_q[idx_s] <= bus.d_wdata;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt_q <= 4'd0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // The port output registers form the last pipeline stage; earlier stages live here.
   generate
      if (LATENCY == 1) begin : g_direct
         assign last_in_s = acc_s;
      end else begin : g_pipe
         rsp_t stg_q [LATENCY-1];
         rsp_t stg_d [LATENCY-1];

         // Shift the response pipe by one stage.
         always_comb begin
            stg_d[0] = acc_s;
            for (int k = 1; k < LATENCY - 1; k++) begin
               stg_d[k] = stg_q[k-1];
            end
         end

         // Response pipe registers.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               for (int k = 0; k < LATENCY - 1; k++) begin
                  stg_q[k] <= '0;
               end
            end else begin
               stg_q <= stg_d;
            end
         end

         assign last_in_s = stg_q[LATENCY-2];
      end
   endgenerate

   // Route the final stage to its owner; the other port keeps its rdata.
   always_comb begin
      i_valid_d = last_in_s.valid & ~last_in_s.port;
      d_valid_d = last_in_s.valid & last_in_s.port;
      i_err_d   = i_valid_d & last_in_s.err;
      d_err_d   = d_valid_d & last_in_s.err;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      if (i_valid_d) begin
         i_rdata_d = last_in_s.data;
      end else begin
         i_rdata_d = i_rdata_q;
      end
      if (d_valid_d) begin
         d_rdata_d = last_in_s.data;
      end else begin
         d_rdata_d = d_rdata_q;
      end
   end

   // Port output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         i_valid_q <= 1'b0;
         i_err_q   <= 1'b0;
         i_rdata_q <= 32'h0000_0000;
         d_valid_q <= 1'b0;
         d_err_q   <= 1'b0;
         d_rdata_q <= 32'h0000_0000;
      end else begin
         i_valid_q <= i_valid_d;
         i_err_q   <= i_err_d;
         i_rdata_q <= i_rdata_d;
         d_valid_q <= d_valid_d;
         d_err_q   <= d_err_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign bus.i_ready = i_ready_s;
   assign bus.d_ready = d_ready_s;
   assign bus.i_valid = i_valid_q;
   assign bus.i_err   = i_err_q;
   assign bus.i_rdata = i_rdata_q;
   assign bus.d_valid = d_valid_q;
   assign bus.d_err   = d_err_q;
   assign bus.d_rdata = d_rdata_q;

endmodule
